reg_file_16x32: RTL and testbench
=================================

// Module: reg_file_16x32
//
// PURPOSE
// - 16-entry x 32-bit general-purpose register file for the datapath: one write port, two read ports.
// - Write path: a 4-to-16 one-hot decoder on dest_sel drives per-register enables; each register loads wr_data.
// - Read path: two independent 16-to-1 x 32-bit multiplexers driven by src1_sel and src2_sel.
// - The block sits between the load/ALU result mux (feeding wr_data) and the ALU operand inputs.
//
// PARAMETERS
// - DATA_W   32  width of each register, wr_data and read outputs
// - ADDR_W   4   select width; number of registers is 2**ADDR_W = 16
//
// PORTS
// - clk       in   1       single clock; all state updates on its rising edge
// - rst       in   1       synchronous, active-high reset
// - wr_en     in   1       write enable; when 1, register[dest_sel] loads wr_data at the rising edge of clk
// - dest_sel  in   ADDR_W  destination register index
// - wr_data   in   DATA_W  write data (LDR/result mux output)
// - src1_sel  in   ADDR_W  read port 1 register index
// - src2_sel  in   ADDR_W  read port 2 register index
// - src1_data out  DATA_W  contents of register[src1_sel]
// - src2_data out  DATA_W  contents of register[src2_sel]
//
// BEHAVIOUR
// - Reset: if rst=1 at a rising edge, all 16 registers become 0, whatever the value of wr_en.
//   - Reset has priority over a write in the same cycle.
//   - As a result, src1_data and src2_data read 0 after reset.
// - Write: if rst=0 and wr_en=1, only register[dest_sel] updates at the edge; the other 15 hold.
// - Write disabled: if wr_en=0, no register changes.
// - Decoder: en[i] = wr_en & (dest_sel == i).
//   - At most one enable is high in any cycle.
//   - All enables are 0 when wr_en=0.
// - Read timing: purely combinational, zero-cycle latency. Outputs follow a select change in the same cycle.
// - Read-during-write to the same index:
//   - The read returns the old value until the edge, and the new value after it.
//   - There is no write-to-read bypass.
// - Both read ports may select the same register, or the register being written; each port is independent.
// - Register 0 is an ordinary register. It is writable and not hardwired to zero.
// - All indices 0..15 are valid; no out-of-range case exists.
// - wr_data is stored unmodified: no sign or width conversion.
//
// STRUCTURE
// - Shared package (regfile_pkg):
//   - constants DATA_W=32, ADDR_W=4, NUM_REGS=16
//   - typedefs for the word (logic [31:0]) and the register index (logic [3:0])
// - Sub-module reg_word: one DATA_W register with clk, rst and en inputs; instantiated 16 times via generate.
// - Decoder and both read muxes are written inline: a one-hot decode, and a case or array index per port.
//
// TESTING
// - Reset: load all registers with nonzero values, assert rst for 1 cycle, sweep both selects 0..15
//   -> every read returns 32'h00000000.
// - Fill: write i*32'h11111111 to register i for i=0..15 with wr_en=1, then sweep src1_sel=i, src2_sel=15-i
//   -> src1_data=i*32'h11111111, src2_data=(15-i)*32'h11111111.
// - Write enable: with reg5=32'h55555555, apply wr_en=0, dest_sel=5, wr_data=32'hDEADBEEF for one edge
//   -> reg5 still reads 32'h55555555.
// - Isolation: write 32'hAAAAAAAA to register 10 only
//   -> registers 9 and 11 keep their prior values; no other register changes.
// - Read-during-write: src1_sel=3 holding 32'h33333333, write 32'hCAFEF00D to 3
//   -> src1_data=32'h33333333 before the edge, 32'hCAFEF00D after it.
// - Reset vs write: rst=1 and wr_en=1, dest_sel=7, wr_data=32'h77777777 in the same cycle
//   -> reg7 reads 32'h00000000.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes, types and write-decode helper for the 16x32 register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] idx_t;

  typedef struct packed {
    logic  en;
    idx_t  dest;
    word_t data;
  } wr_req_t;

  // One-hot write enable: bit idx set only when en is high.
  function automatic logic [NUM_REGS-1:0] decode_onehot(input logic en, input idx_t idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = en;
    return v;
  endfunction

endpackage

// File: rtl/reg_word.sv
// Single DATA_W register with synchronous reset and load enable.
module reg_word
  import regfile_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_en,
  input  word_t i_d,
  output word_t o_q
);

  word_t r_q;

  // Reset wins over a load in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file_16x32.sv
// 16x32 register file: one write port, two combinational read ports, no bypass.
module reg_file_16x32
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_dest_sel,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_src1_sel,
  input  logic [ADDR_W-1:0] i_src2_sel,
  output logic [DATA_W-1:0] o_src1_data,
  output logic [DATA_W-1:0] o_src2_data
);

  wr_req_t             w_wr;
  logic [NUM_REGS-1:0] w_en;
  word_t               w_regs [NUM_REGS];

  assign w_wr = '{en: i_wr_en, dest: i_dest_sel, data: i_wr_data};

  always_comb begin
    w_en = '0;
    w_en = decode_onehot(w_wr.en, w_wr.dest);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    reg_word u_reg (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (w_en[g]),
      .i_d   (w_wr.data),
      .o_q   (w_regs[g])
    );
  end

  // Reads see stored contents only; a same-cycle write appears after the edge.
  assign o_src1_data = w_regs[i_src1_sel];
  assign o_src2_data = w_regs[i_src2_sel];

endmodule

// File: tb/tb_reg_file_16x32.sv
// Randomized scoreboard bench for reg_file_16x32 against an array model.
module tb_reg_file_16x32;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  dest_sel;
  logic [31:0] wr_data;
  logic [3:0]  src1_sel;
  logic [3:0]  src2_sel;
  logic [31:0] src1_data;
  logic [31:0] src2_data;

  reg_file_16x32 dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_dest_sel  (dest_sel),
    .i_wr_data   (wr_data),
    .i_src1_sel  (src1_sel),
    .i_src2_sel  (src2_sel),
    .o_src1_data (src1_data),
    .o_src2_data (src2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [16];
  logic        rd_valid;
  int          checks;
  int          failures;

  // One cycle of stimulus; expected reads reflect contents before this edge.
  task automatic step(input logic r, input logic we, input logic [3:0] d,
                      input logic [31:0] wd, input logic [3:0] s1,
                      input logic [3:0] s2, input logic chk, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; dest_sel = d; wr_data = wd;
    src1_sel = s1; src2_sel = s2;
    rd_valid = chk;
    if (chk) begin
      e.name = nm; e.s1 = s1; e.s2 = s2; e.e1 = model[s1]; e.e2 = model[s2];
      q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
    end else if (we) begin
      model[d] = wd;
    end
  endtask

  // Monitor: compares whenever a checked read is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rd_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty: read presented with no expectation");
        end else begin
          e = q.pop_front();
          if (src1_data !== e.e1) begin
            failures++;
            $display("FAIL %s port1 sel=%0d got=%h exp=%h", e.name, e.s1, src1_data, e.e1);
          end
          checks++;
          if (src2_data !== e.e2) begin
            failures++;
            $display("FAIL %s port2 sel=%0d got=%h exp=%h", e.name, e.s2, src2_data, e.e2);
          end
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; rd_valid = 1'b0;
    rst = 1'b1; wr_en = 1'b0; dest_sel = '0; wr_data = '0;
    src1_sel = '0; src2_sel = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    step(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, "init");
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, "init");
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'(i), 4'(15 - i), 1'b1, "reset_state");

    // Load nonzero, then reset while a write is requested.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'(i), $urandom | 32'h1, 4'($urandom), 4'($urandom), 1'b1, "load");
    step(1'b1, 1'b1, 4'($urandom), 32'hFFFF_FFFF, 4'd1, 4'd2, 1'b1, "pre_reset");
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'(i), 4'(i), 1'b1, "reset_sweep");

    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'(i), 32'(i) * 32'h1111_1111, 4'd0, 4'd15, 1'b1, "fill_wr");
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'(i), 4'(15 - i), 1'b1, "fill_sweep");

    step(1'b0, 1'b0, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd5, 1'b1, "wr_disabled");
    step(1'b0, 1'b0, 4'd0, 32'h0, 4'd5, 4'd0, 1'b1, "wr_disabled_after");

    step(1'b0, 1'b1, 4'd10, 32'hAAAA_AAAA, 4'd9, 4'd11, 1'b1, "isolation_wr");
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'(i), 4'd10, 1'b1, "isolation_sweep");

    step(1'b0, 1'b1, 4'd3, 32'hCAFE_F00D, 4'd3, 4'd3, 1'b1, "rdw_before");
    step(1'b0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 1'b1, "rdw_after");

    step(1'b1, 1'b1, 4'd7, 32'h7777_7777, 4'd7, 4'd0, 1'b1, "rst_vs_wr");
    step(1'b0, 1'b0, 4'd0, 32'h0, 4'd7, 4'd0, 1'b1, "rst_vs_wr_after");

    for (int n = 0; n < 400; n++)
      step(($urandom % 64) == 0, $urandom % 2 == 0, 4'($urandom), $urandom,
           4'($urandom), 4'($urandom), 1'b1, "random");

    @(negedge clk);
    rd_valid = 1'b0;
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
